// File: rtl/fxps_pe_gen.sv
// rtl/fxps_pe_gen.sv - fixed-point MAC processing element with row delay buffer; saturation enabled by FXPS_PE_SAT_EN
module fxps_pe_gen #(
    parameter int WIDTH = 8,
    parameter int FRAC  = 3,
    parameter int DEPTH = 3
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en_in,
    input  logic             in_row,
    input  logic [WIDTH-1:0] in_data,
    input  logic             acc_clr,
    input  logic             en_out,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             ovf
);

`ifdef FXPS_PE_SAT_EN
    localparam logic [WIDTH-1:0] W_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] W_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [2*WIDTH-1:0] P_MAX = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [2*WIDTH-1:0] P_MIN = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
    logic signed [2*WIDTH-1:0] prod_shr;
    logic        [WIDTH:0]     sum_ext;
`endif

    logic [WIDTH-1:0] row_buf_q [DEPTH];
    logic [WIDTH-1:0] row_buf_d [DEPTH];
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic             mul_v_q, mul_v_d;
    logic [WIDTH-1:0] prod_q, prod_d;
    logic             prod_v_q, prod_v_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             out_valid_q, out_valid_d;
    logic             ovf_q, ovf_d;

    logic signed [2*WIDTH-1:0] opa_ext, opb_ext;
    logic [WIDTH-1:0] acc_base;
    logic [WIDTH-1:0] sum_val;
    logic             prod_sat, sum_sat;

    // Row delay line: shift on a row sample, hold otherwise
    always_comb begin
        row_buf_d = row_buf_q;
        if (en_in && in_row) begin
            row_buf_d[0] = in_data;
            for (int i = 1; i < DEPTH; i++) begin
                row_buf_d[i] = row_buf_q[i-1];
            end
        end
    end

    // Stage 0: a column sample captures the pre-shift buffer tail as operand A
    always_comb begin
        opa_d   = opa_q;
        opb_d   = opb_q;
        mul_v_d = 1'b0;
        if (en_in && !in_row) begin
            opa_d   = row_buf_q[DEPTH-1];
            opb_d   = in_data;
            mul_v_d = 1'b1;
        end
    end

    // Stage 1: full-precision product, floor-shifted by FRAC, reduced to WIDTH
    always_comb begin
        opa_ext  = {{WIDTH{opa_q[WIDTH-1]}}, opa_q};
        opb_ext  = {{WIDTH{opb_q[WIDTH-1]}}, opb_q};
        prod_d   = prod_q;
        prod_v_d = mul_v_q;
`ifdef FXPS_PE_SAT_EN
        prod_shr = (opa_ext * opb_ext) >>> FRAC;
        prod_sat = (prod_shr > P_MAX) || (prod_shr < P_MIN);
        if (mul_v_q) begin
            if (prod_shr > P_MAX) begin
                prod_d = W_MAX;
            end else if (prod_shr < P_MIN) begin
                prod_d = W_MIN;
            end else begin
                prod_d = prod_shr[WIDTH-1:0];
            end
        end
`else
        prod_sat = 1'b0;
        if (mul_v_q) begin
            prod_d = WIDTH'((opa_ext * opb_ext) >>> FRAC);
        end
`endif
    end

    // Stage 2: clear-then-add accumulate, valid pulse and sticky overflow
    always_comb begin
        acc_base = acc_clr ? '0 : acc_q;
`ifdef FXPS_PE_SAT_EN
        sum_ext = {acc_base[WIDTH-1], acc_base} + {prod_q[WIDTH-1], prod_q};
        sum_sat = sum_ext[WIDTH] ^ sum_ext[WIDTH-1];
        if (sum_sat) begin
            sum_val = sum_ext[WIDTH] ? W_MIN : W_MAX;
        end else begin
            sum_val = sum_ext[WIDTH-1:0];
        end
`else
        sum_sat = 1'b0;
        sum_val = acc_base + prod_q;
`endif
        acc_d       = prod_v_q ? sum_val : acc_base;
        out_valid_d = prod_v_q;
        ovf_d       = acc_clr ? 1'b0
                              : (ovf_q | (mul_v_q & prod_sat) | (prod_v_q & sum_sat));
    end

    // Pipeline registers, all cleared asynchronously so in-flight work is dropped
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                row_buf_q[i] <= '0;
            end
            opa_q       <= '0;
            opb_q       <= '0;
            mul_v_q     <= 1'b0;
            prod_q      <= '0;
            prod_v_q    <= 1'b0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            row_buf_q   <= row_buf_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            mul_v_q     <= mul_v_d;
            prod_q      <= prod_d;
            prod_v_q    <= prod_v_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_data  = en_out ? acc_q : '0;
    assign out_valid = out_valid_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_fxps_pe_gen.sv
// tb/tb_fxps_pe_gen.sv - scoreboard bench for fxps_pe_gen against an arithmetic reference model
module tb_fxps_pe_gen;
    localparam int W    = 8;
    localparam int F    = 3;
    localparam int D    = 3;
    localparam int MAXV = (1 << (W-1)) - 1;
    localparam int MINV = -(1 << (W-1));

    typedef struct { int acc; bit ovf; } exp_t;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         en_in = 1'b0;
    logic         in_row = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         acc_clr = 1'b0;
    logic         en_out = 1'b1;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         ovf;

    fxps_pe_gen #(.WIDTH(W), .FRAC(F), .DEPTH(D)) dut (
        .clk(clk), .rstn(rstn), .en_in(en_in), .in_row(in_row), .in_data(in_data),
        .acc_clr(acc_clr), .en_out(en_out), .out_data(out_data),
        .out_valid(out_valid), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state: row buffer as a queue (index 0 = newest)
    int   rowq[$];
    bit   s1_v, s2_v;
    int   s1_a, s1_b, s2_p;
    int   m_acc;
    bit   m_ovf, m_valid;
    int   vis_acc;
    bit   vis_ovf, vis_valid;
    exp_t sb[$];

    function automatic void chk(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endfunction

    function automatic int u(input int v);
        return v & ((1 << W) - 1);
    endfunction

    function automatic int sx(input logic [W-1:0] v);
        return v[W-1] ? int'(v) - (1 << W) : int'(v);
    endfunction

    function automatic int reduce(input int v, output bit sat);
        sat = 1'b0;
`ifdef FXPS_PE_SAT_EN
        if (v > MAXV) begin v = MAXV; sat = 1'b1; end
        else if (v < MINV) begin v = MINV; sat = 1'b1; end
`else
        v = ((v % (1 << W)) + (1 << W)) % (1 << W);
        if (v > MAXV) v = v - (1 << W);
`endif
        return v;
    endfunction

    // advance the reference model across one clock edge with the given inputs
    function automatic void model_step(input bit ei, input bit ir, input logic [W-1:0] d, input bit clr);
        bit ssat = 1'b0;
        bit psat = 1'b0;
        int newp = 0;
        int raw;
        m_valid = 1'b0;
        if (clr) m_acc = 0;
        if (s2_v) begin
            m_acc   = reduce(m_acc + s2_p, ssat);
            m_valid = 1'b1;
        end
        if (s1_v) begin
            raw  = int'($floor(real'(s1_a * s1_b) / real'(1 << F)));
            newp = reduce(raw, psat);
        end
        if (clr) m_ovf = 1'b0;
        else     m_ovf = m_ovf | psat | ssat;
        if (m_valid) sb.push_back('{m_acc, m_ovf});
        s2_v = s1_v;
        s2_p = newp;
        s1_v = ei && !ir;
        if (s1_v) begin
            s1_a = rowq[D-1];
            s1_b = sx(d);
        end
        if (ei && ir) begin
            rowq.push_front(sx(d));
            void'(rowq.pop_back());
        end
    endfunction

    function automatic void model_reset();
        rowq.delete();
        for (int i = 0; i < D; i++) rowq.push_back(0);
        s1_v = 0; s2_v = 0; s1_a = 0; s1_b = 0; s2_p = 0;
        m_acc = 0; m_ovf = 0; m_valid = 0;
        vis_acc = 0; vis_ovf = 0; vis_valid = 0;
        sb.delete();
    endfunction

    task automatic cycle(input bit ei, input bit ir, input logic [W-1:0] d, input bit clr, input bit eo);
        en_in = ei; in_row = ir; in_data = d; acc_clr = clr; en_out = eo;
        model_step(ei, ir, d, clr);
        @(posedge clk);
        vis_acc = m_acc; vis_ovf = m_ovf; vis_valid = m_valid;
        #1;
    endtask

    task automatic rows3(input logic [W-1:0] last);
        cycle(1, 1, last, 0, 1);
        cycle(1, 1, '0, 0, 1);
        cycle(1, 1, '0, 0, 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, '0, 0, 1);
    endtask

    // monitor: every cycle against visible model state, and pop the scoreboard on each valid pulse
    always @(negedge clk) begin
        exp_t e;
        chk("out_valid", int'(out_valid), int'(vis_valid));
        chk("out_data", int'(out_data), en_out ? u(vis_acc) : 0);
        chk("ovf", int'(ovf), int'(vis_ovf));
        if (out_valid) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("sb_acc", int'(out_data), en_out ? u(e.acc) : 0);
                chk("sb_ovf", int'(ovf), int'(e.ovf));
            end
        end
    end

    initial begin
        model_reset();
        #3;
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_ovf", int'(ovf), 0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        #1;

        // rows 8,16,24 then column 16 -> acc 0x10
        cycle(1, 1, 8'd8, 0, 1);
        cycle(1, 1, 8'd16, 0, 1);
        cycle(1, 1, 8'd24, 0, 1);
        cycle(1, 0, 8'd16, 0, 1);
        idle(2);
        chk("basic_acc", int'(out_data), 'h10);
        chk("basic_valid", int'(out_valid), 1);
        en_out = 1'b0;
        #1 chk("basic_gated", int'(out_data), 0);
        idle(1);

        // negative operands and floor rounding
        cycle(0, 0, '0, 1, 1);
        rows3(8'hF8);
        cycle(1, 0, 8'h08, 0, 1);
        idle(2);
        chk("neg_acc", int'(out_data), 'hF8);
        rows3(8'hFF);
        cycle(1, 0, 8'h01, 0, 1);
        idle(2);
        chk("floor_acc", int'(out_data), 'hF7);

        // product overflow
        cycle(0, 0, '0, 1, 1);
        rows3(8'd127);
        cycle(1, 0, 8'd127, 0, 1);
        idle(2);
`ifdef FXPS_PE_SAT_EN
        chk("ovf_acc", int'(out_data), 'h7F);
        chk("ovf_flag", int'(ovf), 1);
`else
        chk("ovf_acc", int'(out_data), 'hE0);
        chk("ovf_flag", int'(ovf), 0);
`endif

        // clear coinciding with an arriving product, then clear alone
        cycle(0, 0, '0, 1, 1);
        rows3(8'd8);
        cycle(1, 0, 8'd16, 0, 1);
        cycle(1, 0, 8'd8, 0, 1);
        idle(1);
        chk("clr_pre", int'(out_data), 'h10);
        cycle(0, 0, '0, 1, 1);
        chk("clr_add", int'(out_data), 'h08);
        chk("clr_ovf", int'(ovf), 0);
        cycle(0, 0, '0, 1, 1);
        chk("clr_only", int'(out_data), 'h00);

        // reset between stage edges discards the in-flight product
        rows3(8'd8);
        cycle(1, 0, 8'd8, 0, 1);
        idle(2);
        chk("rst_pre", int'(out_data), 'h08);
        cycle(1, 0, 8'd8, 0, 1);
        idle(1);
        rstn = 1'b0;
        model_reset();
        #1;
        chk("rst_mid_data", int'(out_data), 0);
        chk("rst_mid_valid", int'(out_valid), 0);
        chk("rst_mid_ovf", int'(ovf), 0);
        @(posedge clk);
        #2 rstn = 1'b1;
        idle(4);

        // back-to-back columns
        rows3(8'd8);
        cycle(1, 0, 8'd8, 0, 1);
        cycle(1, 0, 8'd8, 0, 1);
        cycle(1, 0, 8'd8, 0, 1);
        chk("b2b_1", int'(out_data), 'h08);
        idle(1);
        chk("b2b_2", int'(out_data), 'h10);
        idle(1);
        chk("b2b_3", int'(out_data), 'h18);
        chk("b2b_valid", int'(out_valid), 1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom % 4) != 0, ($urandom % 3) == 0, W'($urandom),
                  ($urandom % 16) == 0, ($urandom % 2) == 0);
        end
        idle(3);
        chk("sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fxps_pe_gen.md
FXPS_PE_GEN -- requirements
Module: fxps_pe_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 8: two's-complement data, product and accumulator width, minimum 4.
REQ-002 SHALL have parameter FRAC, default 3: fractional bits of all data, 0 <= FRAC < WIDTH.
REQ-003 SHALL have parameter DEPTH, default 3: row delay-buffer stages, minimum 1.
REQ-004 SHALL have one clock and an asynchronous, active-low reset; the ports are clk and rstn.
REQ-005 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-006 SHALL have port rstn, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port en_in, input, 1 bit: in_data valid this cycle.
REQ-008 SHALL have port in_row, input, 1 bit: 1 routes in_data to the row buffer; 0 routes it to multiplier operand B.
REQ-009 SHALL have port in_data, input, WIDTH bits: signed fixed-point sample.
REQ-010 SHALL have port acc_clr, input, 1 bit: synchronous accumulator clear.
REQ-011 SHALL have port en_out, input, 1 bit: output gate.
REQ-012 SHALL have port out_data, output, WIDTH bits: accumulator value when en_out=1, else 0.
REQ-013 SHALL have port out_valid, output, 1 bit: one-cycle pulse on each accumulator update.
REQ-014 SHALL have port ovf, output, 1 bit: sticky overflow flag.

Function
REQ-015 SHALL shift in_data into buf[0] and buf[i-1] into buf[i] when en_in=1 and in_row=1, and hold all stages otherwise.
REQ-016 SHALL, on an edge with en_in=1 and in_row=0 (stage 0), capture opA from buf[DEPTH-1] as it was before that edge, capture opB from in_data, and set mul_v.
REQ-017 SHALL, at stage 1, register the product as the full 2*WIDTH signed product arithmetic-shifted right by FRAC (floor, toward minus infinity) and reduced to WIDTH bits, together with prod_v.
REQ-018 SHALL, at stage 2, register acc as acc plus the product, with out_valid=1 for that cycle; acc becomes visible two edges after the operand-B edge.
REQ-019 SHALL leave acc unchanged when prod_v=0, unless acc_clr=1.
REQ-020 SHALL, on acc_clr=1 with prod_v=0, set acc to 0.
REQ-021 SHALL, on acc_clr=1 with prod_v=1, clear then add, so acc is loaded with the product.
REQ-022 SHALL, in every cycle acc_clr=1, also clear ovf.
REQ-023 SHALL accept a new operand B every cycle with no stalls, at a throughput of 1 MAC per cycle.
REQ-024 SHALL, when rows arrive in the same cycle as a column, apply the column first: the shift happens on the same edge, and operand A is the pre-shift buf[DEPTH-1].
REQ-025 SHALL drive out_data combinationally from acc gated by en_out; out_valid is not gated by en_out.

Reset
REQ-026 SHALL, while rstn=0, clear asynchronously: all buf stages, opA, opB, mul_v, product register, prod_v, acc, out_valid and ovf.
REQ-027 SHALL therefore drive out_data=0, out_valid=0 and ovf=0 while rstn=0, independent of clk.
REQ-028 SHALL discard in-flight products on reset mid-operation; no out_valid pulse follows reset release without a new operand B.

Configuration
REQ-029 SHALL be controlled by macro FXPS_PE_SAT_EN.
REQ-030 SHALL, with FXPS_PE_SAT_EN defined, saturate the product reduction and the accumulator sum to the range -2^(WIDTH-1) .. 2^(WIDTH-1)-1, and set ovf on either saturation until acc_clr or reset.
REQ-031 SHALL, without FXPS_PE_SAT_EN, truncate the product and wrap the sum modulo 2^WIDTH, with ovf tied to 0.

Verification (WIDTH=8, FRAC=3, DEPTH=3)
REQ-032 SHALL cover: rows 8, 16, 24 then column 16 -> opA=8; two edges later acc=16 (0x10), out_valid pulses once, out_data=0x10 with en_out=1 and 0x00 with en_out=0.
REQ-033 SHALL cover: buf[2]=0xF8 (-1.0), column 0x08 -> acc=0xF8; then buf[2]=0xFF with column 0x01 -> product -1 (floor), acc=0xF7.
REQ-034 SHALL cover: buf[2]=127, column 127 -> with FXPS_PE_SAT_EN acc=0x7F and ovf=1; without it the product is 0xE0 and acc=0xE0 with ovf=0.
REQ-035 SHALL cover: acc=0x10, acc_clr=1 in the same cycle as a product of 8 arrives -> acc=0x08, ovf cleared; acc_clr alone -> acc=0x00.
REQ-036 SHALL cover: column issued, then rstn pulsed low between edges one and two -> outputs are 0 immediately, and no out_valid follows release.
REQ-037 SHALL cover: back-to-back columns 8, 8, 8 with buf[2]=8 -> acc steps 1, 2, 3 (0x08, 0x10, 0x18) on consecutive cycles, with out_valid high for 3 cycles.
